// File: rtl/grid_io_pkg.sv
// Shared types and field indices for the perimeter I/O grid tile.
package grid_io_pkg;

  localparam int unsigned CFG_BITS_PER_IO = 2;
  localparam int unsigned CFG_DIR_OUT     = 0;
  localparam int unsigned CFG_INVERT      = 1;

  typedef struct packed {
    logic invert;
    logic dir_out;
  } io_cfg_t;

endpackage

// File: rtl/grid_io_cfg_chain.sv
// Configuration shift chain with saturating shift counter and shadow (active) register.
// Optional odd-parity check on load when CCFF_PARITY_EN is defined.
module grid_io_cfg_chain #(
  parameter int unsigned PAD_BITS  = 8,
  parameter int unsigned CHAIN_LEN = 8
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic                ccff_head,
  input  logic                ccff_shift_en,
  input  logic                ccff_load,
  output logic [PAD_BITS-1:0] active,
  output logic                ccff_tail,
  output logic                cfg_done,
  output logic                cfg_err
);

  localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(CHAIN_LEN);

  logic [CHAIN_LEN-1:0] chain_q, chain_d;
  logic [PAD_BITS-1:0]  active_q, active_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 load_ok;

`ifdef CCFF_PARITY_EN
  assign load_ok = ^chain_q;
`else
  assign load_ok = 1'b1;
`endif

  always_comb begin
    chain_d  = chain_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (ccff_shift_en) begin
      chain_d = {chain_q[CHAIN_LEN-2:0], ccff_head};
    end
    // Load samples the pre-shift chain; a concurrent shift counts as the first of the next batch.
    if (ccff_load) begin
      if (load_ok) begin
        active_d = chain_q[PAD_BITS-1:0];
      end
`ifdef CCFF_PARITY_EN
      err_d = ~load_ok;
`else
      err_d = 1'b0;
`endif
      cnt_d = ccff_shift_en ? CntW'(1) : '0;
    end else if (ccff_shift_en && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      chain_q  <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      chain_q  <= chain_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign active    = active_q;
  assign ccff_tail = chain_q[CHAIN_LEN-1];
  assign cfg_done  = (cnt_q == CntMax);
  assign cfg_err   = err_q;

endmodule

// File: rtl/grid_io_cfg_bank.sv
// Perimeter I/O grid tile: serially configured pads with combinational, isolatable datapath.
// Build option: define CCFF_PARITY_EN to append an odd-parity bit to the config chain.
module grid_io_cfg_bank
  import grid_io_pkg::*;
#(
  parameter int unsigned NUM_IO   = 4,
  parameter int unsigned CFG_BITS = CFG_BITS_PER_IO
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              isol_n,
  input  logic              ccff_head,
  input  logic              ccff_shift_en,
  input  logic              ccff_load,
  input  logic [NUM_IO-1:0] gfpga_pad_io_soc_in,
  output logic [NUM_IO-1:0] gfpga_pad_io_soc_out,
  output logic [NUM_IO-1:0] gfpga_pad_io_soc_dir,
  input  logic [NUM_IO-1:0] io_outpad,
  output logic [NUM_IO-1:0] io_inpad,
  output logic              ccff_tail,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam int unsigned PAD_BITS = NUM_IO * CFG_BITS;
`ifdef CCFF_PARITY_EN
  localparam int unsigned CHAIN_LEN = PAD_BITS + 1;
`else
  localparam int unsigned CHAIN_LEN = PAD_BITS;
`endif

  logic [PAD_BITS-1:0] active;

  grid_io_cfg_chain #(
    .PAD_BITS  (PAD_BITS),
    .CHAIN_LEN (CHAIN_LEN)
  ) u_chain (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_load     (ccff_load),
    .active        (active),
    .ccff_tail     (ccff_tail),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err)
  );

  for (genvar i = 0; i < NUM_IO; i++) begin : g_pad
    io_cfg_t cfg;
    logic    drive;

    assign cfg   = active[i*CFG_BITS +: CFG_BITS_PER_IO];
    assign drive = cfg.dir_out & isol_n;

    assign gfpga_pad_io_soc_dir[i] = ~drive;
    assign gfpga_pad_io_soc_out[i] = drive ? (io_outpad[i] ^ cfg.invert) : 1'b0;
    assign io_inpad[i] = (isol_n & ~cfg.dir_out) ? (gfpga_pad_io_soc_in[i] ^ cfg.invert) : 1'b0;
  end

endmodule

// File: tb/tb_grid_io_cfg_bank.sv
// Self-checking bench for grid_io_cfg_bank: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_grid_io_cfg_bank;

  localparam int NIO = 4;
  localparam int PB  = NIO * 2;
`ifdef CCFF_PARITY_EN
  localparam int CL = PB + 1;
`else
  localparam int CL = PB;
`endif

  logic           prog_clk;
  logic           prog_reset;
  logic           isol_n;
  logic           ccff_head;
  logic           ccff_shift_en;
  logic           ccff_load;
  logic [NIO-1:0] soc_in;
  logic [NIO-1:0] soc_out;
  logic [NIO-1:0] soc_dir;
  logic [NIO-1:0] io_outpad;
  logic [NIO-1:0] io_inpad;
  logic           ccff_tail;
  logic           cfg_done;
  logic           cfg_err;

  int checks = 0;
  int errors = 0;

  // Reference model: bit history (newest at back), committed config, shifts since load.
  bit             hist[$];
  logic [PB-1:0]  m_active;
  int             m_cnt;
  logic           m_err;

  grid_io_cfg_bank #(
    .NUM_IO   (NIO),
    .CFG_BITS (2)
  ) dut (
    .prog_clk             (prog_clk),
    .prog_reset           (prog_reset),
    .isol_n               (isol_n),
    .ccff_head            (ccff_head),
    .ccff_shift_en        (ccff_shift_en),
    .ccff_load            (ccff_load),
    .gfpga_pad_io_soc_in  (soc_in),
    .gfpga_pad_io_soc_out (soc_out),
    .gfpga_pad_io_soc_dir (soc_dir),
    .io_outpad            (io_outpad),
    .io_inpad             (io_inpad),
    .ccff_tail            (ccff_tail),
    .cfg_done             (cfg_done),
    .cfg_err              (cfg_err)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  function automatic logic [CL-1:0] m_chain();
    logic [CL-1:0] v = '0;
    for (int k = 0; k < CL && k < hist.size(); k++) v[k] = hist[hist.size() - 1 - k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NIO-1:0] e_dir, e_out, e_in;
    logic [CL-1:0]  ch;
    logic           dir, inv, drv;
    for (int i = 0; i < NIO; i++) begin
      dir = m_active[2*i];
      inv = m_active[2*i+1];
      drv = dir & isol_n;
      e_dir[i] = ~drv;
      e_out[i] = drv ? (io_outpad[i] ^ inv) : 1'b0;
      e_in[i]  = (isol_n && !dir) ? (soc_in[i] ^ inv) : 1'b0;
    end
    ch = m_chain();
    chk({tag, ".dir"},  32'(soc_dir),  32'(e_dir));
    chk({tag, ".out"},  32'(soc_out),  32'(e_out));
    chk({tag, ".in"},   32'(io_inpad), 32'(e_in));
    chk({tag, ".tail"}, 32'(ccff_tail), 32'(ch[CL-1]));
    chk({tag, ".done"}, 32'(cfg_done), 32'(m_cnt == CL));
    chk({tag, ".err"},  32'(cfg_err),  32'(m_err));
  endtask

  task automatic model_reset();
    hist.delete();
    m_active = '0;
    m_cnt    = 0;
    m_err    = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    prog_reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 prog_reset = 1'b0;
  endtask

  task automatic step(input string tag, input logic sh, input logic hd, input logic ld);
    logic [CL-1:0] ch;
    ccff_shift_en = sh;
    ccff_head     = hd;
    ccff_load     = ld;
    @(posedge prog_clk);
    ch = m_chain();
    if (ld) begin
`ifdef CCFF_PARITY_EN
      if (^ch) begin
        m_active = ch[PB-1:0];
        m_err    = 1'b0;
      end else begin
        m_err = 1'b1;
      end
`else
      m_active = ch[PB-1:0];
`endif
      m_cnt = sh ? 1 : 0;
    end else if (sh && m_cnt < CL) begin
      m_cnt++;
    end
    if (sh) begin
      hist.push_back(hd);
      if (hist.size() > CL) void'(hist.pop_front());
    end
    #1;
    ccff_shift_en = 1'b0;
    ccff_load     = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] pat;
    logic [8:0] pv;
    prog_reset    = 1'b1;
    isol_n        = 1'b1;
    ccff_head     = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_load     = 1'b0;
    soc_in        = '0;
    io_outpad     = 4'b1111;
    model_reset();
    #2;
    check_all("reset");
    chk("reset.dir_const", 32'(soc_dir), 32'hF);
    #1 prog_reset = 1'b0;

    // Shift 00_01_10_11 MSB first, then commit.
    pat = 8'b00_01_10_11;
    for (int j = 7; j >= 0; j--) step("shift", 1'b1, pat[j], 1'b0);
`ifndef CCFF_PARITY_EN
    chk("shift.done_const", 32'(cfg_done), 32'h1);
`endif
    step("load", 1'b0, 1'b0, 1'b1);
`ifndef CCFF_PARITY_EN
    chk("load.dir_const", 32'(soc_dir), 32'hA);
    chk("load.out_const", 32'(soc_out), 32'h4);
    chk("load.in_const", 32'(io_inpad), 32'h2);
    chk("load.done_const", 32'(cfg_done), 32'h0);
`endif

    // New bits shifted without load must not disturb pads.
    for (int j = 0; j < 8; j++) step("glitch", 1'b1, 1'($urandom_range(0, 1)), 1'b0);

    // Isolation takes effect combinationally.
    soc_in = 4'b1111;
    #1 check_all("pre_isol");
    isol_n = 1'b0;
    #1 check_all("isol");
    chk("isol.dir_const", 32'(soc_dir), 32'hF);
    chk("isol.out_const", 32'(soc_out), 32'h0);
    chk("isol.in_const", 32'(io_inpad), 32'h0);
    isol_n = 1'b1;
    #1 check_all("unisol");

    // Saturation, then load+shift together.
    for (int j = 0; j < 20; j++) step("sat", 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    chk("sat.done_const", 32'(cfg_done), 32'h1);
    step("ld_sh", 1'b1, 1'b1, 1'b1);
    chk("ld_sh.done_const", 32'(cfg_done), 32'h0);
    for (int j = 0; j < CL - 1; j++) step("after_ld_sh", 1'b1, 1'($urandom_range(0, 1)), 1'b0);

    // Reset in the middle of shifting.
    for (int j = 0; j < 3; j++) step("pre_rst", 1'b1, 1'b1, 1'b0);
    @(negedge prog_clk);
    do_reset("mid_rst");
    for (int j = 0; j < CL; j++) step("post_rst", 1'b1, 1'($urandom_range(0, 1)), 1'b0);

`ifdef CCFF_PARITY_EN
    pv = 9'($urandom());
    if (^pv) pv[0] = ~pv[0];
    for (int j = 8; j >= 0; j--) step("par_bad_sh", 1'b1, pv[j], 1'b0);
    step("par_bad_ld", 1'b0, 1'b0, 1'b1);
    chk("par_bad.err_const", 32'(cfg_err), 32'h1);
    pv[3] = ~pv[3];
    for (int j = 8; j >= 0; j--) step("par_ok_sh", 1'b1, pv[j], 1'b0);
    step("par_ok_ld", 1'b0, 1'b0, 1'b1);
    chk("par_ok.err_const", 32'(cfg_err), 32'h0);
`else
    pv = '0;
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      isol_n    = ($urandom_range(0, 9) != 0);
      io_outpad = 4'($urandom());
      soc_in    = 4'($urandom());
      if ($urandom_range(0, 99) == 0) begin
        @(negedge prog_clk);
        do_reset("rnd_rst");
      end else begin
        step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom()), 1'($urandom_range(0, 11) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
